// File: rtl/rom_fetch_master.sv
// Reads a run of consecutive 32-bit words from a 1-cycle-latency memory port
// and streams them out through a small first-word-fall-through FIFO.
//
// state | meaning
// IDLE  | waiting for start_i
// FETCH | issuing reads while words remain and the FIFO has room for them
// DRAIN | all reads issued; waiting for the last word to leave the FIFO
module rom_fetch_master #(
  parameter int FifoDepth = 4,
  parameter int LenWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         start_addr_i,
  input  logic [LenWidth-1:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                req_o,
  output logic [31:0]         addr_o,
  input  logic [31:0]         rdata_i,
  output logic                valid_o,
  output logic [31:0]         data_o,
  input  logic                ready_i
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [31:0]         addr_q;
  logic [LenWidth-1:0] remaining;
  logic                inflight;

  logic [31:0]         mem [FifoDepth];
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [CntW-1:0]     count;
  logic                push;
  logic                pop;

  // Reads in flight count against FIFO space so a returning word always fits.
  assign req_o   = (state == FETCH) && (remaining != '0) &&
                   ((32'(count) + 32'(inflight)) < 32'(FifoDepth));
  assign addr_o  = addr_q;
  assign busy_o  = (state != IDLE);
  assign push    = inflight;
  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i;
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      inflight <= req_o;
      done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state     <= FETCH;
              addr_q    <= {start_addr_i[31:2], 2'b00};
              remaining <= len_i;
            end
          end
        end
        FETCH: begin
          if (req_o) begin
            addr_q    <= addr_q + 32'd4;
            remaining <= remaining - 1'b1;
            if (remaining == LenWidth'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight && (count == '0)) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (count == CntW'(FifoDepth))));

endmodule

// File: tb/tb_rom_fetch_master.sv
// Randomised bench for rom_fetch_master: a queue-based reference of the
// expected read addresses and stream words, checked by a negedge monitor.
module tb_rom_fetch_master;

  localparam int FifoDepth = 4;
  localparam int LenWidth  = 16;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                start_i = 1'b0;
  logic [31:0]         start_addr_i = '0;
  logic [LenWidth-1:0] len_i = '0;
  logic                busy_o, done_o, req_o, valid_o;
  logic [31:0]         addr_o, data_o;
  logic [31:0]         rdata_i = '0;
  logic                ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  rom_fetch_master #(.FifoDepth(FifoDepth), .LenWidth(LenWidth)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .req_o(req_o), .addr_o(addr_o),
    .rdata_i(rdata_i), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i)
  );

  // Memory: data returns the cycle after the request; garbage otherwise.
  always @(posedge clk_i) rdata_i <= req_o ? (addr_o ^ K) : $urandom;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_data[$];
  int done_cnt = 0;
  int req_cnt  = 0;
  int pop_cnt  = 0;
  int ready_mode = 1;  // 0: low, 1: high, 2: random
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_data", data_o, hold_data);
      end
      hold_prev = valid_o && !ready_i;
      hold_data = data_o;
      if (req_o) begin
        req_cnt++;
        if (exp_req.size() == 0) chk("req_unexpected", 32'(req_o), 32'd0);
        else chk("req_addr", addr_o, exp_req.pop_front());
      end
      if (valid_o && ready_i) begin
        pop_cnt++;
        if (exp_data.size() == 0) chk("data_unexpected", 32'(valid_o), 32'd0);
        else chk("data", data_o, exp_data.pop_front());
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic push_exp(input logic [31:0] addr, input int len);
    logic [31:0] a;
    a = addr & ~32'd3;
    for (int i = 0; i < len; i++) begin
      exp_req.push_back(a);
      exp_data.push_back(a ^ K);
      a = a + 32'd4;
    end
  endtask

  task automatic pulse_start(input logic [31:0] addr, input int len);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    start_addr_i = addr;
    len_i = LenWidth'(len);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_busy_after"}, 32'(busy_o), 32'd0);
    chk({name, "_left_req"}, 32'(exp_req.size()), 32'd0);
    chk({name, "_left_data"}, 32'(exp_data.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, 32'(busy_o), 32'd0);
    chk({name, "_done"}, 32'(done_o), 32'd0);
    chk({name, "_req"}, 32'(req_o), 32'd0);
    chk({name, "_addr"}, addr_o, 32'd0);
    chk({name, "_valid"}, 32'(valid_o), 32'd0);
    chk({name, "_data"}, data_o, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int d0, r0, p0, n, vseen;
    logic [31:0] a;
    int len;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outputs("reset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // 1: short transfer, latency and back-to-back output
    ready_mode = 1;
    push_exp(32'h1C00_0080, 2);
    d0 = done_cnt;
    pulse_start(32'h1C00_0080, 2);
    @(negedge clk_i);
    chk("t1_req_cycle1", 32'(req_o), 32'd1);
    @(negedge clk_i);
    chk("t1_valid_cycle2", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    chk("t1_valid_cycle3", 32'(valid_o), 32'd1);
    @(negedge clk_i);
    chk("t1_valid_cycle4", 32'(valid_o), 32'd1);
    wait_done("t1", d0);

    // 2: consumer stalled, only FifoDepth reads may issue
    ready_mode = 0;
    push_exp(32'h0000_2000, 10);
    d0 = done_cnt;
    r0 = req_cnt;
    pulse_start(32'h0000_2000, 10);
    repeat (20) @(negedge clk_i);
    chk("t2_req_limit", 32'(req_cnt - r0), 32'(FifoDepth));
    chk("t2_req_low", 32'(req_o), 32'd0);
    ready_mode = 1;
    wait_done("t2", d0);

    // 3: address wrap
    ready_mode = 2;
    push_exp(32'hFFFF_FFF8, 4);
    d0 = done_cnt;
    pulse_start(32'hFFFF_FFF8, 4);
    wait_done("t3", d0);

    // 4: zero length
    ready_mode = 1;
    d0 = done_cnt;
    r0 = req_cnt;
    pulse_start(32'h0000_0040, 0);
    @(negedge clk_i);
    chk("t4_done_cycle1", 32'(done_o), 32'd1);
    vseen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (valid_o) vseen++;
    end
    chk("t4_valid_never", 32'(vseen), 32'd0);
    chk("t4_no_req", 32'(req_cnt - r0), 32'd0);
    chk("t4_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t4_busy", 32'(busy_o), 32'd0);

    // 5: unaligned start, second start while busy is ignored
    ready_mode = 2;
    push_exp(32'h0000_0013, 6);
    d0 = done_cnt;
    pulse_start(32'h0000_0013, 6);
    repeat (2) @(posedge clk_i);
    #1;
    start_i = 1'b1;
    start_addr_i = 32'h0000_5000;
    len_i = 16'd3;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done("t5", d0);

    // 6: reset mid-transfer, then a clean restart
    ready_mode = 1;
    push_exp(32'h0000_3000, 8);
    d0 = done_cnt;
    p0 = pop_cnt;
    pulse_start(32'h0000_3000, 8);
    n = 0;
    while (pop_cnt - p0 < 3 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("t6_three_popped", 32'(pop_cnt - p0 >= 3), 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    exp_req.delete();
    exp_data.delete();
    #1;
    chk_reset_outputs("t6_rst");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outputs("t6_rst_hold");
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    push_exp(32'h0000_4000, 5);
    d0 = done_cnt;
    pulse_start(32'h0000_4000, 5);
    wait_done("t6_restart", d0);

    // random transfers
    for (int t = 0; t < 12; t++) begin
      a = $urandom;
      len = $urandom_range(1, 12);
      ready_mode = $urandom_range(1, 2);
      push_exp(a, len);
      d0 = done_cnt;
      pulse_start(a, len);
      wait_done("rand", d0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
